// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_ctrl_pkg
// Brief    : Shared states, opcode/funct constants and control encodings.
// Revision : 1.0
// ============================================================================
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RESET, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXEC, ALUWB, ADDIEXEC, ADDIWB, BRANCH, JUMP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage
`default_nettype wire

// File: rtl/mips_alu_decoder.sv
`default_nettype none
// ============================================================================
// Module   : mips_alu_decoder
// Brief    : Maps ALUOp/Funct to the 3-bit ALU control and flags legal functs.
// Revision : 1.0
// ============================================================================
module mips_alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic [5:0] Funct,
    output logic [2:0] ALU_CTRL,
    output logic       funct_valid
);

    logic [2:0] w_funct_ctrl;

    always_comb begin
        w_funct_ctrl = ALU_ADD;
        funct_valid  = 1'b1;
        case (Funct)
            FN_ADD:  w_funct_ctrl = ALU_ADD;
            FN_SUB:  w_funct_ctrl = ALU_SUB;
            FN_AND:  w_funct_ctrl = ALU_AND;
            FN_OR:   w_funct_ctrl = ALU_OR;
            FN_SLT:  w_funct_ctrl = ALU_SLT;
            default: funct_valid  = 1'b0;
        endcase
    end

    always_comb begin
        case (ALUOp)
            ALUOP_ADD: ALU_CTRL = ALU_ADD;
            ALUOP_SUB: ALU_CTRL = ALU_SUB;
            default:   ALU_CTRL = w_funct_ctrl;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_ctrl
// Brief    : Multi-cycle MIPS control FSM with memory stall and retire counter.
// Revision : 1.0
// ============================================================================
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           Opcode,
    input  logic [5:0]           Funct,
    input  logic                 Zero_Flag,
    input  logic                 mem_ready,
    output logic                 IorD,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 RegDst,
    output logic                 MemtoReg,
    output logic                 RegWrite,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           PCSrc,
    output logic                 PCEn,
    output logic [2:0]           ALU_CTRL,
    output logic                 illegal_op,
    output logic [CNT_WIDTH-1:0] instr_retired
);

    localparam logic [CNT_WIDTH-1:0] c_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t     r_state;
    logic [CNT_WIDTH-1:0] r_retired;
    logic [1:0] w_alu_op;
    logic [2:0] w_alu_ctrl;
    logic       w_alu_en;
    logic       w_funct_valid;
    logic       w_opcode_valid;
    logic       w_illegal;
    logic       w_retire;

    mips_alu_decoder u_alu_dec (
        .ALUOp       (w_alu_op),
        .Funct       (Funct),
        .ALU_CTRL    (w_alu_ctrl),
        .funct_valid (w_funct_valid)
    );

    always_comb begin
        case (Opcode)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: w_opcode_valid = 1'b1;
            default:                                       w_opcode_valid = 1'b0;
        endcase
    end

    assign w_illegal = (r_state == DECODE) &&
                       (!w_opcode_valid || ((Opcode == OP_RTYPE) && !w_funct_valid));

    always_comb begin
        case (r_state)
            MEMWB, ALUWB, ADDIWB, BRANCH, JUMP: w_retire = 1'b1;
            MEMWR:                              w_retire = mem_ready;
            default:                            w_retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_RESET;
            r_retired <= '0;
        end else begin
            if (w_retire)
                r_retired <= r_retired + c_one;
            case (r_state)
                S_RESET:  r_state <= FETCH;
                FETCH:    if (mem_ready) r_state <= DECODE;
                DECODE: begin
                    if (w_illegal) begin
                        r_state <= FETCH;
                    end else begin
                        case (Opcode)
                            OP_LW, OP_SW: r_state <= MEMADR;
                            OP_RTYPE:     r_state <= EXEC;
                            OP_BEQ:       r_state <= BRANCH;
                            OP_ADDI:      r_state <= ADDIEXEC;
                            OP_J:         r_state <= JUMP;
                            default:      r_state <= FETCH;
                        endcase
                    end
                end
                MEMADR:   r_state <= (Opcode == OP_LW) ? MEMRD : MEMWR;
                MEMRD:    if (mem_ready) r_state <= MEMWB;
                MEMWR:    if (mem_ready) r_state <= FETCH;
                EXEC:     r_state <= ALUWB;
                ADDIEXEC: r_state <= ADDIWB;
                MEMWB, ALUWB, ADDIWB, BRANCH, JUMP: r_state <= FETCH;
                default:  r_state <= S_RESET;
            endcase
        end
    end

    // Moore decode; only the FETCH writes and the BRANCH PC load look at inputs.
    always_comb begin
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_B;
        PCSrc      = PCSRC_ALU;
        PCEn       = 1'b0;
        w_alu_op   = ALUOP_ADD;
        w_alu_en   = 1'b0;
        case (r_state)
            FETCH: begin
                ALUSrcB  = SRCB_FOUR;
                PCSrc    = PCSRC_ALU;
                w_alu_en = 1'b1;
                IRWrite  = mem_ready;
                PCEn     = mem_ready;
            end
            DECODE: begin
                ALUSrcB  = SRCB_IMMSH;
                w_alu_en = 1'b1;
            end
            MEMADR, ADDIEXEC: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = SRCB_IMM;
                w_alu_en = 1'b1;
            end
            MEMRD: IorD = 1'b1;
            MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            EXEC: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = SRCB_B;
                w_alu_op = ALUOP_FUNCT;
                w_alu_en = 1'b1;
            end
            ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            ADDIWB: RegWrite = 1'b1;
            BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = SRCB_B;
                w_alu_op = ALUOP_SUB;
                w_alu_en = 1'b1;
                PCSrc    = PCSRC_ALUOUT;
                PCEn     = Zero_Flag;
            end
            JUMP: begin
                PCSrc = PCSRC_JUMP;
                PCEn  = 1'b1;
            end
            default: ;
        endcase
    end

    assign ALU_CTRL      = w_alu_en ? w_alu_ctrl : ALU_AND;
    assign illegal_op    = w_illegal;
    assign instr_retired = r_retired;

endmodule
`default_nettype wire
